// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter that shares one IP transmit port between PORTS frame sources.
// The grant is held from header acceptance until the owner's payload tlast is transferred.
module ip_tx_arbiter #(
    parameter int PORTS = 2,
    parameter int SEL_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [PORTS-1:0]      s_ip_hdr_valid,
    output logic [PORTS-1:0]      s_ip_hdr_ready,
    input  logic [6*PORTS-1:0]    s_ip_dscp,
    input  logic [2*PORTS-1:0]    s_ip_ecn,
    input  logic [16*PORTS-1:0]   s_ip_length,
    input  logic [8*PORTS-1:0]    s_ip_ttl,
    input  logic [8*PORTS-1:0]    s_ip_protocol,
    input  logic [32*PORTS-1:0]   s_ip_source_ip,
    input  logic [32*PORTS-1:0]   s_ip_dest_ip,
    input  logic [8*PORTS-1:0]    s_ip_payload_axis_tdata,
    input  logic [PORTS-1:0]      s_ip_payload_axis_tvalid,
    output logic [PORTS-1:0]      s_ip_payload_axis_tready,
    input  logic [PORTS-1:0]      s_ip_payload_axis_tlast,
    input  logic [PORTS-1:0]      s_ip_payload_axis_tuser,

    output logic                  m_ip_hdr_valid,
    input  logic                  m_ip_hdr_ready,
    output logic [5:0]            m_ip_dscp,
    output logic [1:0]            m_ip_ecn,
    output logic [15:0]           m_ip_length,
    output logic [7:0]            m_ip_ttl,
    output logic [7:0]            m_ip_protocol,
    output logic [31:0]           m_ip_source_ip,
    output logic [31:0]           m_ip_dest_ip,
    output logic [7:0]            m_ip_payload_axis_tdata,
    output logic                  m_ip_payload_axis_tvalid,
    input  logic                  m_ip_payload_axis_tready,
    output logic                  m_ip_payload_axis_tlast,
    output logic                  m_ip_payload_axis_tuser,

    output logic                  grant_valid,
    output logic [SEL_W-1:0]      grant_sel,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t              state;
    state_t              state_next;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    next_ptr;
    logic [SEL_W-1:0]    winner;
    logic                found;
    logic [SEL_W:0]      cand;
    logic                hdr_pulse;
    logic [103:0]        hdr_q;
    logic                payload_done;

    logic [103:0]        hdr_arr   [PORTS];
    logic [7:0]          tdata_arr [PORTS];

    genvar g;
    generate
        for (g = 0; g < PORTS; g++) begin : g_unpack
            assign hdr_arr[g] = {s_ip_dscp[6*g +: 6], s_ip_ecn[2*g +: 2],
                                 s_ip_length[16*g +: 16], s_ip_ttl[8*g +: 8],
                                 s_ip_protocol[8*g +: 8], s_ip_source_ip[32*g +: 32],
                                 s_ip_dest_ip[32*g +: 32]};
            assign tdata_arr[g] = s_ip_payload_axis_tdata[8*g +: 8];
        end
    endgenerate

    assign {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
            m_ip_protocol, m_ip_source_ip, m_ip_dest_ip} = hdr_q;

    // Circular search starting at rr_ptr; the candidate index is wrapped explicitly so PORTS need not be a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(PORTS))
                cand = cand - (SEL_W+1)'(PORTS);
            if (!found && s_ip_hdr_valid[cand[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[SEL_W-1:0];
            end
        end
    end

    assign payload_done = (state == PAYLOAD) && s_ip_payload_axis_tvalid[grant_sel] &&
                          m_ip_payload_axis_tready && s_ip_payload_axis_tlast[grant_sel];
    assign next_ptr     = (grant_sel == SEL_W'(PORTS-1)) ? '0 : grant_sel + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = HDR;
            HDR:     if (m_ip_hdr_ready) state_next = PAYLOAD;
            PAYLOAD: if (payload_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Header is captured on the grant edge, so a source dropping valid afterwards cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_sel <= '0;
            rr_ptr    <= '0;
            hdr_pulse <= 1'b0;
            hdr_q     <= '0;
        end else begin
            hdr_pulse <= 1'b0;
            if (state == IDLE && found) begin
                grant_sel <= winner;
                hdr_pulse <= 1'b1;
                hdr_q     <= hdr_arr[winner];
            end
            if (payload_done)
                rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        s_ip_hdr_ready           = '0;
        s_ip_payload_axis_tready = '0;
        m_ip_hdr_valid           = (state == HDR);
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        grant_valid              = (state != IDLE);
        busy                     = (state != IDLE);
        if (hdr_pulse)
            s_ip_hdr_ready[grant_sel] = 1'b1;
        if (state == PAYLOAD) begin
            m_ip_payload_axis_tdata             = tdata_arr[grant_sel];
            m_ip_payload_axis_tvalid            = s_ip_payload_axis_tvalid[grant_sel];
            m_ip_payload_axis_tlast             = s_ip_payload_axis_tlast[grant_sel];
            m_ip_payload_axis_tuser             = s_ip_payload_axis_tuser[grant_sel];
            s_ip_payload_axis_tready[grant_sel] = m_ip_payload_axis_tready;
        end
    end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Randomized bench for ip_tx_arbiter: sources and sink are driven from $urandom and every
// cycle is compared against a frame-level round-robin model kept in the bench.
module tb_ip_tx_arbiter;

    localparam int PORTS = 2;
    localparam int SEL_W = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PORTS-1:0]      s_ip_hdr_valid;
    logic [PORTS-1:0]      s_ip_hdr_ready;
    logic [6*PORTS-1:0]    s_ip_dscp;
    logic [2*PORTS-1:0]    s_ip_ecn;
    logic [16*PORTS-1:0]   s_ip_length;
    logic [8*PORTS-1:0]    s_ip_ttl;
    logic [8*PORTS-1:0]    s_ip_protocol;
    logic [32*PORTS-1:0]   s_ip_source_ip;
    logic [32*PORTS-1:0]   s_ip_dest_ip;
    logic [8*PORTS-1:0]    s_ip_payload_axis_tdata;
    logic [PORTS-1:0]      s_ip_payload_axis_tvalid;
    logic [PORTS-1:0]      s_ip_payload_axis_tready;
    logic [PORTS-1:0]      s_ip_payload_axis_tlast;
    logic [PORTS-1:0]      s_ip_payload_axis_tuser;
    logic                  m_ip_hdr_valid;
    logic                  m_ip_hdr_ready;
    logic [5:0]            m_ip_dscp;
    logic [1:0]            m_ip_ecn;
    logic [15:0]           m_ip_length;
    logic [7:0]            m_ip_ttl;
    logic [7:0]            m_ip_protocol;
    logic [31:0]           m_ip_source_ip;
    logic [31:0]           m_ip_dest_ip;
    logic [7:0]            m_ip_payload_axis_tdata;
    logic                  m_ip_payload_axis_tvalid;
    logic                  m_ip_payload_axis_tready;
    logic                  m_ip_payload_axis_tlast;
    logic                  m_ip_payload_axis_tuser;
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_sel;
    logic                  busy;

    logic [103:0]          hdr [PORTS];
    int                    total = 0;
    int                    bad = 0;

    // Stimulus knobs (percent probabilities) and per-source frame progress.
    int  vp [PORTS];
    int  tv_pct, hr_pct, tr_pct, len_fixed, len_max, cyc;
    bit  tr_toggle, fixed_hdr;
    bit  pending [PORTS];
    int  beat [PORTS];
    int  flen [PORTS];

    // Reference model: owner index (-1 when nobody holds the port), header phase flag, pointer.
    int            m_owner;
    bit            m_hdr;
    bit            m_pulse;
    int            m_ptr;
    logic [103:0]  m_fields;
    logic [SEL_W-1:0] grants [$];

    genvar g;
    generate
        for (g = 0; g < PORTS; g++) begin : g_pack
            assign s_ip_dscp[6*g +: 6]        = hdr[g][103:98];
            assign s_ip_ecn[2*g +: 2]         = hdr[g][97:96];
            assign s_ip_length[16*g +: 16]    = hdr[g][95:80];
            assign s_ip_ttl[8*g +: 8]         = hdr[g][79:72];
            assign s_ip_protocol[8*g +: 8]    = hdr[g][71:64];
            assign s_ip_source_ip[32*g +: 32] = hdr[g][63:32];
            assign s_ip_dest_ip[32*g +: 32]   = hdr[g][31:0];
        end
    endgenerate

    ip_tx_arbiter #(.PORTS(PORTS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
        .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
        .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
        .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
        .s_ip_payload_axis_tdata(s_ip_payload_axis_tdata),
        .s_ip_payload_axis_tvalid(s_ip_payload_axis_tvalid),
        .s_ip_payload_axis_tready(s_ip_payload_axis_tready),
        .s_ip_payload_axis_tlast(s_ip_payload_axis_tlast),
        .s_ip_payload_axis_tuser(s_ip_payload_axis_tuser),
        .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
        .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
        .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_ip_payload_axis_tdata(m_ip_payload_axis_tdata),
        .m_ip_payload_axis_tvalid(m_ip_payload_axis_tvalid),
        .m_ip_payload_axis_tready(m_ip_payload_axis_tready),
        .m_ip_payload_axis_tlast(m_ip_payload_axis_tlast),
        .m_ip_payload_axis_tuser(m_ip_payload_axis_tuser),
        .grant_valid(grant_valid), .grant_sel(grant_sel), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int newLen();
        return (len_fixed > 0) ? len_fixed : int'($urandom_range(1, len_max));
    endfunction

    function automatic int pickWinner();
        int idx;
        for (int k = 0; k < PORTS; k++) begin
            idx = (m_ptr + k) % PORTS;
            if (s_ip_hdr_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clearInputs();
        for (int i = 0; i < PORTS; i++) begin
            pending[i] = 1'b0;
            beat[i]    = 0;
            flen[i]    = newLen();
            hdr[i]     = '0;
        end
        s_ip_hdr_valid           = '0;
        s_ip_payload_axis_tdata  = '0;
        s_ip_payload_axis_tvalid = '0;
        s_ip_payload_axis_tlast  = '0;
        s_ip_payload_axis_tuser  = '0;
        m_ip_hdr_ready           = 1'b0;
        m_ip_payload_axis_tready = 1'b0;
    endtask

    task automatic modelReset();
        m_owner  = -1;
        m_hdr    = 1'b0;
        m_pulse  = 1'b0;
        m_ptr    = 0;
        m_fields = '0;
    endtask

    task automatic applyStimulus();
        logic [127:0] r;
        cyc++;
        for (int i = 0; i < PORTS; i++) begin
            if (!pending[i] && ($urandom_range(1, 100) <= vp[i])) begin
                pending[i] = 1'b1;
                r = {$urandom, $urandom, $urandom, $urandom};
                hdr[i] = r[103:0];
                if (fixed_hdr && i == 0)
                    hdr[i] = {6'd0, 2'd0, 16'd28, 8'd64, 8'd17, 32'hC0A80102, 32'hC0A8010A};
            end
            s_ip_hdr_valid[i]               = pending[i];
            s_ip_payload_axis_tvalid[i]     = ($urandom_range(1, 100) <= tv_pct);
            s_ip_payload_axis_tdata[8*i +: 8] = 8'($urandom);
            s_ip_payload_axis_tlast[i]      = (beat[i] == flen[i] - 1);
            s_ip_payload_axis_tuser[i]      = s_ip_payload_axis_tlast[i] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        m_ip_hdr_ready           = ($urandom_range(1, 100) <= hr_pct);
        m_ip_payload_axis_tready = tr_toggle ? 1'(cyc % 2) : ($urandom_range(1, 100) <= tr_pct);
    endtask

    task automatic checkAll();
        logic [PORTS-1:0] exp_hr;
        logic [PORTS-1:0] exp_tr;
        bit payload;
        payload = (m_owner >= 0) && !m_hdr;
        exp_hr = '0;
        exp_tr = '0;
        if (m_pulse) exp_hr[m_owner] = 1'b1;
        if (payload) exp_tr[m_owner] = m_ip_payload_axis_tready;
        checkOutput("hdr_valid", 128'(m_ip_hdr_valid), 128'(m_owner >= 0 && m_hdr));
        checkOutput("hdr_ready", 128'(s_ip_hdr_ready), 128'(exp_hr));
        checkOutput("hdr_fields", 128'({m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
                    m_ip_protocol, m_ip_source_ip, m_ip_dest_ip}), 128'(m_fields));
        checkOutput("grant_valid", 128'(grant_valid), 128'(m_owner >= 0));
        checkOutput("busy", 128'(busy), 128'(m_owner >= 0));
        if (m_owner >= 0)
            checkOutput("grant_sel", 128'(grant_sel), 128'(m_owner));
        checkOutput("s_tready", 128'(s_ip_payload_axis_tready), 128'(exp_tr));
        checkOutput("m_tvalid", 128'(m_ip_payload_axis_tvalid),
                    128'(payload ? s_ip_payload_axis_tvalid[m_owner] : 1'b0));
        if (payload) begin
            checkOutput("m_tdata", 128'(m_ip_payload_axis_tdata), 128'(s_ip_payload_axis_tdata[8*m_owner +: 8]));
            checkOutput("m_tlast", 128'(m_ip_payload_axis_tlast), 128'(s_ip_payload_axis_tlast[m_owner]));
            checkOutput("m_tuser", 128'(m_ip_payload_axis_tuser), 128'(s_ip_payload_axis_tuser[m_owner]));
        end
        if (m_pulse) grants.push_back(grant_sel);
    endtask

    // Advance the model across the coming clock edge using the inputs the bench is driving.
    task automatic modelStep();
        int w;
        int o;
        if (m_owner < 0) begin
            m_pulse = 1'b0;
            w = pickWinner();
            if (w >= 0) begin
                m_owner  = w;
                m_hdr    = 1'b1;
                m_pulse  = 1'b1;
                m_fields = hdr[w];
            end
        end else if (m_hdr) begin
            if (m_pulse && s_ip_hdr_valid[m_owner]) pending[m_owner] = 1'b0;
            m_pulse = 1'b0;
            if (m_ip_hdr_ready) m_hdr = 1'b0;
        end else begin
            o = m_owner;
            if (s_ip_payload_axis_tvalid[o] && m_ip_payload_axis_tready) begin
                if (s_ip_payload_axis_tlast[o]) begin
                    beat[o]  = 0;
                    flen[o]  = newLen();
                    m_ptr    = (o + 1) % PORTS;
                    m_owner  = -1;
                end else begin
                    beat[o]++;
                end
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
            #1;
            checkAll();
            modelStep();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        #1;
        checkAll();
        checkOutput("rst_grant_sel", 128'(grant_sel), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic asyncResetTest();
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        vp[0] = 100; vp[1] = 100;
        tv_pct = 100; hr_pct = 100; tr_pct = 100; len_fixed = 8;
        while (n < 200 && !hit) begin
            @(negedge clk);
            applyStimulus();
            #1;
            checkAll();
            if (m_owner >= 0 && !m_hdr) hit = 1'b1;
            else modelStep();
            n++;
        end
        checkOutput("reach_payload", 128'(hit), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
        checkOutput("async_hdr_ready", 128'(s_ip_hdr_ready), 128'(0));
        checkOutput("async_m_tvalid", 128'(m_ip_payload_axis_tvalid), 128'(0));
        checkOutput("async_s_tready", 128'(s_ip_payload_axis_tready), 128'(0));
        checkOutput("async_grant_valid", 128'(grant_valid), 128'(0));
        checkOutput("async_busy", 128'(busy), 128'(0));
        checkOutput("async_grant_sel", 128'(grant_sel), 128'(0));
        clearInputs();
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vp[0] = 0; vp[1] = 100;
        grants.delete();
        runCycles(20);
        checkOutput("post_reset_grant", (grants.size() > 0) ? 128'(grants[0]) : 128'hdead, 128'(1));
    endtask

    initial begin
        cyc = 0; tr_toggle = 1'b0; fixed_hdr = 1'b0; len_max = 6;
        vp[0] = 0; vp[1] = 0;
        tv_pct = 100; hr_pct = 100; tr_pct = 100; len_fixed = 8;
        clearInputs();
        modelReset();

        $display("[TB] single source, 8-byte frames");
        vp[0] = 100; fixed_hdr = 1'b1;
        doReset();
        runCycles(25);
        fixed_hdr = 1'b0;

        $display("[TB] contention and round robin");
        vp[0] = 100; vp[1] = 100;
        doReset();
        grants.delete();
        runCycles(80);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("rr_order%0d", k),
                        (k < grants.size()) ? 128'(grants[k]) : 128'hdead, 128'(k % 2));

        $display("[TB] backpressure");
        vp[0] = 100; vp[1] = 0; hr_pct = 0;
        doReset();
        runCycles(6);
        hr_pct = 100; tr_toggle = 1'b1;
        runCycles(40);
        tr_toggle = 1'b0;

        $display("[TB] asynchronous reset mid-payload");
        asyncResetTest();

        $display("[TB] randomized traffic");
        vp[0] = 60; vp[1] = 60;
        tv_pct = 70; hr_pct = 60; tr_pct = 60; len_fixed = 0; len_max = 6;
        runCycles(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Round-robin scheduler that shares the single IP transmit input of the IP/ARP block between PORTS independent IP frame sources (e.g. UDP engine, ICMP responder).
- Arbitrates on header valid, registers the winning header and forwards it downstream.
- Holds the grant until the granted source's payload tlast is transferred, so frames are never interleaved.

Parameters:
- PORTS, 2, number of requesters (2..4).
- SEL_W, 1, grant index width; must satisfy 2^SEL_W >= PORTS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_ip_hdr_valid  in  PORTS  per-source header valid
- s_ip_hdr_ready  out  PORTS  per-source header accept (one-hot pulse)
- s_ip_dscp  in  6*PORTS  packed per source, source i at [6i+5:6i]; same packing for the fields below
- s_ip_ecn  in  2*PORTS
- s_ip_length  in  16*PORTS
- s_ip_ttl  in  8*PORTS
- s_ip_protocol  in  8*PORTS
- s_ip_source_ip  in  32*PORTS
- s_ip_dest_ip  in  32*PORTS
- s_ip_payload_axis_tdata  in  8*PORTS
- s_ip_payload_axis_tvalid  in  PORTS
- s_ip_payload_axis_tready  out  PORTS
- s_ip_payload_axis_tlast  in  PORTS
- s_ip_payload_axis_tuser  in  PORTS
- m_ip_hdr_valid  out  1  header valid to IP block
- m_ip_hdr_ready  in  1
- m_ip_dscp / m_ip_ecn / m_ip_length / m_ip_ttl / m_ip_protocol / m_ip_source_ip / m_ip_dest_ip  out  6/2/16/8/8/32/32  registered header fields
- m_ip_payload_axis_tdata  out  8
- m_ip_payload_axis_tvalid  out  1
- m_ip_payload_axis_tready  in  1
- m_ip_payload_axis_tlast  out  1
- m_ip_payload_axis_tuser  out  1
- grant_valid  out  1  a frame is owned
- grant_sel  out  SEL_W  index of owning source
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all ready/valid outputs = 0; grant_sel = 0; rr_ptr = 0; header registers = 0.
- States: IDLE, HDR, PAYLOAD.
- IDLE:
  - Winner = first i with s_ip_hdr_valid[i], searching circularly from rr_ptr.
  - If any source is valid: next cycle, state = HDR, grant_sel = winner, header fields latched from the winner, s_ip_hdr_ready[winner] = 1 for exactly that one cycle, m_ip_hdr_valid = 1.
  - Latency from s_ip_hdr_valid to m_ip_hdr_valid is 1 cycle.
- HDR:
  - m_ip_hdr_valid and the header fields are held stable until m_ip_hdr_ready.
  - On the handshake cycle: m_ip_hdr_valid deasserts next cycle; state = PAYLOAD.
- PAYLOAD:
  - Combinational pass-through: m_tdata/tvalid/tlast/tuser = s_*[grant_sel].
  - s_ip_payload_axis_tready[grant_sel] = m_ip_payload_axis_tready; all other s_tready = 0.
  - On tvalid && tready && tlast: state = IDLE, rr_ptr = (grant_sel+1) mod PORTS.
- Outside PAYLOAD: m_ip_payload_axis_tvalid = 0 and all s_tready = 0, so no payload moves before the header is accepted.
- IDLE is held for at least 1 cycle between frames; back-to-back frames therefore cost one idle cycle.
- Fairness: a source that is continuously valid waits at most PORTS-1 frames.
- Simultaneous requests: rr_ptr decides; ties are impossible.
- A source dropping s_ip_hdr_valid after the grant has no effect, because its header is already latched.
- Wrap: rr_ptr is compared mod PORTS; values >= PORTS never occur.
- tuser is forwarded unchanged; an error frame still ends on tlast.
- grant_valid = (state != IDLE).
- Reset mid-frame: all handshakes drop immediately; the downstream truncated frame is the IP block's concern.

Test Plan:
- Single source: port0 sends a header (length=28, dest 192.168.1.10) plus a 8-byte payload → m_ip_hdr_valid 1 cycle after s valid; s_ip_hdr_ready[0] is a one-cycle pulse; 8 bytes appear unchanged; back in IDLE after tlast.
- Contention: ports 0 and 1 valid in the same cycle after reset → port0 is granted first, port1 second; port1's payload tready stays 0 during port0's frame.
- Round robin: both ports continuously requesting for 6 frames → grant order 0,1,0,1,0,1.
- Backpressure: m_ip_hdr_ready held low 5 cycles, then m_tready toggling every cycle → header fields stable throughout; no byte lost or duplicated; tlast is accepted exactly once.
- Async reset: assert rst_n low mid-payload without a clock edge → all valid/ready outputs are 0 immediately; after release, port1 requesting is granted from rr_ptr=0.
- tuser: port1 frame with tuser=1 on its last byte → m_tuser=1 on that byte; next grant goes to port0 (if requesting).
